fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Control block in front of the instruction fetch stage. It takes a byte-wide command stream from the debug link and sequences the fetch datapath through its phases: loading a program byte-by-byte into instruction memory, resetting the PC, free-running until the program-end marker, or single-stepping one clock at a time. It also reports state, the executed-cycle count and completion events back to the debug side.

## Interface
- NB_DATA, 32, width of cycle counter
- NB_BYTE, 8, command/program byte width
- NB_LEN, 16, program length field width (bytes; sent as two bytes, little-endian)
- i_clock  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_cmd_byte  in  NB_BYTE  command/length/program byte
- i_cmd_valid  in  1  i_cmd_byte valid
- o_cmd_ready  out  1  byte accepted on edge where valid && ready
- i_is_end  in  1  program-end flag from fetch stage
- o_load_program_byte  out  NB_BYTE  byte to instruction memory
- o_load_program_write_enable  out  1  instruction memory write strobe
- o_pc_reset  out  1  synchronous PC clear to fetch stage
- o_pipeline_enable  out  1  PC/pipeline advance enable
- o_state  out  4  current state encoding (debug)
- o_cycle_count  out  NB_DATA  enabled cycles since last run/step start
- o_done  out  1  one-cycle pulse: execution reached end
- o_error  out  1  one-cycle pulse: unknown command in IDLE

## Operation
- Commands (accepted in IDLE only): 0x4C 'L' load, 0x43 'C' continuous run, 0x53 'S' step mode. Any other byte in IDLE: consumed, o_error pulses, stay IDLE.
- States and encodings: IDLE=0, LEN_LO=1, LEN_HI=2, LOAD=3, PC_RST=4, RUN=5, STEP_WAIT=6, STEP_EXEC=7.
- IDLE -'L'-> LEN_LO -byte-> LEN_HI -byte-> LOAD. If the length is 0, go to PC_RST instead of LOAD.
- LOAD: each accepted byte is registered to o_load_program_byte with o_load_program_write_enable=1 on the next cycle. The remaining-byte counter decrements on each acceptance. When the last byte is accepted, go to PC_RST.
- PC_RST: o_pc_reset=1 for exactly one cycle, then IDLE.
- IDLE -'C'-> RUN. On acceptance, o_cycle_count clears to 0.
  - RUN: o_pipeline_enable = !i_is_end (combinational).
  - If i_is_end is sampled high in RUN: o_done pulses next cycle, state -> IDLE.
- IDLE -'S'-> STEP_WAIT. On acceptance, o_cycle_count clears to 0.
  - In STEP_WAIT, i_is_end has priority: if high, o_cmd_ready=0, o_done pulses, state -> IDLE.
  - Otherwise 0x4E 'N' -> STEP_EXEC; 0x45 'E' -> IDLE with no o_done; other bytes are consumed and ignored.
  - STEP_EXEC: o_pipeline_enable=1 for one cycle, then STEP_WAIT.
- o_cycle_count increments by 1 on every cycle with o_pipeline_enable=1, and wraps modulo 2^NB_DATA.
- o_cmd_ready = 1 in IDLE, LEN_LO, LEN_HI, LOAD, and in STEP_WAIT when !i_is_end. It is 0 in PC_RST, RUN and STEP_EXEC.
- o_pipeline_enable = 0 in every state other than RUN and STEP_EXEC.

## Timing
- Async reset values: state IDLE, o_load_program_byte=0, o_load_program_write_enable=0, o_pc_reset=0, o_pipeline_enable=0, o_cycle_count=0, o_done=0, o_error=0, length counter 0, o_cmd_ready=1 after release.
- Reset mid-LOAD: writes stop immediately and no o_pc_reset is issued. Partially loaded memory is left as-is.
- Reset mid-RUN or mid-step: o_pipeline_enable drops asynchronously and no o_done is issued.
- Write strobe latency: 1 cycle after the byte is accepted. Back-to-back valid bytes give back-to-back strobes.
- o_pc_reset is asserted one cycle after the final byte is accepted, which is the same cycle as the last write strobe.
- o_done and o_error are registered one-cycle pulses, asserted the cycle after the triggering edge.
- A 'C' accepted while i_is_end=1 gives zero enable cycles, o_cycle_count=0, and o_done one cycle after RUN is entered.
- Length 0xFFFF is legal: 65535 bytes are written.

## Test plan
- Load: send 4C 08 00 then 8 bytes 11..88 with valid held high → 8 consecutive strobes carrying 11..88, o_pc_reset pulses once with the 8th strobe, state returns to 0.
- Zero-length load: send 4C 00 00 → no strobes, o_pc_reset pulses 1 cycle after the second length byte.
- Run: send 43, assert i_is_end 10 cycles after RUN is entered → exactly 10 enable cycles, o_cycle_count=10, one o_done pulse, state 0, ready=1.
- Step: send 53 then 4E three times, then 45 → three single-cycle enable pulses, o_cycle_count=3, no o_done, state 0. Repeat with i_is_end raised in STEP_WAIT → ready=0, o_done pulse.
- Error/ignore: send 0x99 in IDLE → o_error one-cycle pulse, no other output changes. Send 0x99 in STEP_WAIT → consumed, no o_error.
- Async reset asserted mid-LOAD after 3 of 8 bytes → all outputs go to 0 immediately, state 0. A subsequent 'L' sequence works normally.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Debug-link command sequencer for the instruction fetch stage: program load,
// PC reset, free run until the end marker, and single-step execution.
module fetch_sequencer #(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8,
    parameter int NB_LEN  = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_BYTE-1:0] i_cmd_byte,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic               i_is_end,
    output logic [NB_BYTE-1:0] o_load_program_byte,
    output logic               o_load_program_write_enable,
    output logic               o_pc_reset,
    output logic               o_pipeline_enable,
    output logic [3:0]         o_state,
    output logic [NB_DATA-1:0] o_cycle_count,
    output logic               o_done,
    output logic               o_error
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_LEN_LO    = 4'd1,
        ST_LEN_HI    = 4'd2,
        ST_LOAD      = 4'd3,
        ST_PC_RST    = 4'd4,
        ST_RUN       = 4'd5,
        ST_STEP_WAIT = 4'd6,
        ST_STEP_EXEC = 4'd7
    } state_t;

    localparam logic [NB_BYTE-1:0] CMD_LOAD = NB_BYTE'(8'h4C);
    localparam logic [NB_BYTE-1:0] CMD_CONT = NB_BYTE'(8'h43);
    localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'(8'h53);
    localparam logic [NB_BYTE-1:0] CMD_NEXT = NB_BYTE'(8'h4E);
    localparam logic [NB_BYTE-1:0] CMD_EXIT = NB_BYTE'(8'h45);

    state_t             state_reg;
    logic [NB_BYTE-1:0] len_lo_reg;
    logic [NB_LEN-1:0]  remaining_reg;
    logic [NB_BYTE-1:0] load_byte_reg;
    logic               write_enable_reg;
    logic               pc_reset_reg;
    logic               done_reg;
    logic               error_reg;
    logic [NB_DATA-1:0] cycle_count_reg;

    logic               cmd_accept;
    logic               pipeline_enable;
    logic [NB_LEN-1:0]  len_full;

    // Ready and enable are decoded from state so an async reset drops them at once.
    always_comb begin
        o_cmd_ready = 1'b0;
        case (state_reg)
            ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_LOAD: o_cmd_ready = 1'b1;
            ST_STEP_WAIT:                           o_cmd_ready = !i_is_end;
            default:                                o_cmd_ready = 1'b0;
        endcase
    end

    always_comb begin
        pipeline_enable = 1'b0;
        case (state_reg)
            ST_RUN:       pipeline_enable = !i_is_end;
            ST_STEP_EXEC: pipeline_enable = 1'b1;
            default:      pipeline_enable = 1'b0;
        endcase
    end

    assign cmd_accept = i_cmd_valid && o_cmd_ready;
    assign len_full   = NB_LEN'({i_cmd_byte, len_lo_reg});

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_reg        <= ST_IDLE;
            len_lo_reg       <= '0;
            remaining_reg    <= '0;
            load_byte_reg    <= '0;
            write_enable_reg <= 1'b0;
            pc_reset_reg     <= 1'b0;
            done_reg         <= 1'b0;
            error_reg        <= 1'b0;
            cycle_count_reg  <= '0;
        end else begin
            write_enable_reg <= 1'b0;
            pc_reset_reg     <= 1'b0;
            done_reg         <= 1'b0;
            error_reg        <= 1'b0;
            if (pipeline_enable) begin
                cycle_count_reg <= cycle_count_reg + NB_DATA'(1);
            end

            case (state_reg)
                ST_IDLE: begin
                    if (cmd_accept) begin
                        case (i_cmd_byte)
                            CMD_LOAD: state_reg <= ST_LEN_LO;
                            CMD_CONT: begin
                                cycle_count_reg <= '0;
                                state_reg       <= ST_RUN;
                            end
                            CMD_STEP: begin
                                cycle_count_reg <= '0;
                                state_reg       <= ST_STEP_WAIT;
                            end
                            default:  error_reg <= 1'b1;
                        endcase
                    end
                end
                ST_LEN_LO: begin
                    if (cmd_accept) begin
                        len_lo_reg <= i_cmd_byte;
                        state_reg  <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (cmd_accept) begin
                        if (len_full == '0) begin
                            pc_reset_reg <= 1'b1;
                            state_reg    <= ST_PC_RST;
                        end else begin
                            remaining_reg <= len_full;
                            state_reg     <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (cmd_accept) begin
                        load_byte_reg    <= i_cmd_byte;
                        write_enable_reg <= 1'b1;
                        remaining_reg    <= remaining_reg - NB_LEN'(1);
                        // PC clear lines up with the final write strobe.
                        if (remaining_reg == NB_LEN'(1)) begin
                            pc_reset_reg <= 1'b1;
                            state_reg    <= ST_PC_RST;
                        end
                    end
                end
                ST_PC_RST: state_reg <= ST_IDLE;
                ST_RUN: begin
                    if (i_is_end) begin
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                ST_STEP_WAIT: begin
                    if (i_is_end) begin
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else if (cmd_accept) begin
                        if (i_cmd_byte == CMD_NEXT) begin
                            state_reg <= ST_STEP_EXEC;
                        end else if (i_cmd_byte == CMD_EXIT) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                ST_STEP_EXEC: state_reg <= ST_STEP_WAIT;
                default:      state_reg <= ST_IDLE;
            endcase
        end
    end

    assign o_load_program_byte         = load_byte_reg;
    assign o_load_program_write_enable = write_enable_reg;
    assign o_pc_reset                  = pc_reset_reg;
    assign o_pipeline_enable           = pipeline_enable;
    assign o_state                     = state_reg;
    assign o_cycle_count               = cycle_count_reg;
    assign o_done                      = done_reg;
    assign o_error                     = error_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: drivers predict timed output events,
// a negedge monitor matches them against what the DUT presents.
`timescale 1ns/1ps
module tb_fetch_sequencer;

    localparam int NB_DATA = 32;
    localparam int NB_BYTE = 8;
    localparam int NB_LEN  = 16;

    localparam int EV_STROBE = 0;
    localparam int EV_PCRST  = 1;
    localparam int EV_DONE   = 2;
    localparam int EV_ERROR  = 3;

    logic               i_clock = 1'b0;
    logic               i_reset = 1'b1;
    logic [NB_BYTE-1:0] i_cmd_byte = '0;
    logic               i_cmd_valid = 1'b0;
    logic               o_cmd_ready;
    logic               i_is_end = 1'b0;
    logic [NB_BYTE-1:0] o_load_program_byte;
    logic               o_load_program_write_enable;
    logic               o_pc_reset;
    logic               o_pipeline_enable;
    logic [3:0]         o_state;
    logic [NB_DATA-1:0] o_cycle_count;
    logic               o_done;
    logic               o_error;

    fetch_sequencer #(.NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE), .NB_LEN(NB_LEN)) dut (
        .i_clock                     (i_clock),
        .i_reset                     (i_reset),
        .i_cmd_byte                  (i_cmd_byte),
        .i_cmd_valid                 (i_cmd_valid),
        .o_cmd_ready                 (o_cmd_ready),
        .i_is_end                    (i_is_end),
        .o_load_program_byte         (o_load_program_byte),
        .o_load_program_write_enable (o_load_program_write_enable),
        .o_pc_reset                  (o_pc_reset),
        .o_pipeline_enable           (o_pipeline_enable),
        .o_state                     (o_state),
        .o_cycle_count               (o_cycle_count),
        .o_done                      (o_done),
        .o_error                     (o_error)
    );

    always #5 i_clock = ~i_clock;

    int cyc = 0;
    always @(posedge i_clock) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int data;
        int cycle;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  en_count = 0;
    longint model_count = 0;

    function automatic string kname(input int k);
        case (k)
            EV_STROBE: return "strobe";
            EV_PCRST:  return "pc_reset";
            EV_DONE:   return "done";
            default:   return "error_pulse";
        endcase
    endfunction

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int data, input int cycle);
        ev_t e;
        e.kind = kind; e.data = data; e.cycle = cycle;
        exp_q.push_back(e);
    endtask

    task automatic match(input int kind, input int data);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: got data %0h at cycle %0d, expected no event", kname(kind), data, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.data != data || e.cycle != cyc) begin
                errors++;
                $display("FAIL event_%s: got %s data %0h cycle %0d, expected %s data %0h cycle %0d",
                         kname(kind), kname(kind), data, cyc, kname(e.kind), e.data, e.cycle);
            end
        end
    endtask

    // Monitor: drains any overdue expectation, then matches events seen this cycle.
    always @(negedge i_clock) begin
        if (!i_reset) begin
            if (o_pipeline_enable) en_count++;
            while (exp_q.size() > 0 && exp_q[0].cycle < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_%s: got nothing, expected data %0h at cycle %0d",
                         kname(exp_q[0].kind), exp_q[0].data, exp_q[0].cycle);
                void'(exp_q.pop_front());
            end
            if (o_load_program_write_enable) match(EV_STROBE, int'(o_load_program_byte));
            if (o_pc_reset) match(EV_PCRST, 0);
            if (o_done)     match(EV_DONE, 0);
            if (o_error)    match(EV_ERROR, 0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clock); #1;
        end
    endtask

    // Presents one byte for a single cycle; acc is the cycle its effect becomes visible.
    task automatic send(input logic [7:0] b, output int acc);
        i_cmd_byte  = b;
        i_cmd_valid = 1'b1;
        @(negedge i_clock);
        check_val("cmd_ready", 64'(o_cmd_ready), 64'd1);
        acc = cyc + 1;
        @(posedge i_clock); #1;
        i_cmd_valid = 1'b0;
    endtask

    task automatic check_idle_state(input string tag);
        check_val({tag, "_state"}, 64'(o_state), 64'd0);
        check_val({tag, "_ready"}, 64'(o_cmd_ready), 64'd1);
        check_val({tag, "_cycle_count"}, 64'(o_cycle_count), 64'(model_count));
    endtask

    // mode 0: bytes 0x11*(i+1); mode 1: random bytes
    task automatic load_prog(input int len, input int mode, input int gap_max);
        int a;
        logic [7:0] b;
        logic [15:0] l;
        l = 16'(len);
        send(8'h4C, a); idle($urandom_range(gap_max, 0));
        send(l[7:0], a); idle($urandom_range(gap_max, 0));
        send(l[15:8], a);
        for (int i = 0; i < len; i++) begin
            if (i > 0) idle($urandom_range(gap_max, 0));
            b = (mode == 0) ? 8'((i + 1) * 17) : 8'($urandom);
            send(b, a);
            push_ev(EV_STROBE, int'(b), a);
        end
        push_ev(EV_PCRST, 0, a);
        idle(1);
        check_idle_state("load");
        $display("load len=%0d done at cycle %0d", len, cyc);
    endtask

    task automatic run_prog(input int k, input bit preset);
        int a;
        int base;
        if (preset) i_is_end = 1'b1;
        send(8'h43, a);
        base = en_count;
        model_count = k;
        idle(k);
        i_is_end = 1'b1;
        push_ev(EV_DONE, 0, cyc + 1);
        @(negedge i_clock);
        check_val("run_ready_low", 64'(o_cmd_ready), 64'd0);
        @(posedge i_clock); #1;
        i_is_end = 1'b0;
        check_val("run_enable_cycles", 64'(en_count - base), 64'(k));
        check_idle_state("run");
        $display("run k=%0d preset=%0d count=%0d", k, preset, o_cycle_count);
    endtask

    function automatic logic [7:0] junk_step();
        logic [7:0] b;
        do b = 8'($urandom); while (b == 8'h4E || b == 8'h45);
        return b;
    endfunction

    task automatic step_prog(input int n, input bit by_end, input bit directed);
        int a;
        int base;
        send(8'h53, a);
        base = en_count;
        model_count = n;
        for (int i = 0; i < n; i++) begin
            if (directed && i == 0) send(8'h99, a);
            else if ($urandom_range(1, 0) == 1) send(junk_step(), a);
            send(8'h4E, a);
            idle(1);
        end
        if (by_end) begin
            i_is_end    = 1'b1;
            i_cmd_byte  = 8'h4E;
            i_cmd_valid = 1'b1;
            push_ev(EV_DONE, 0, cyc + 1);
            @(negedge i_clock);
            check_val("step_ready_low", 64'(o_cmd_ready), 64'd0);
            @(posedge i_clock); #1;
            i_cmd_valid = 1'b0;
            i_is_end    = 1'b0;
        end else begin
            send(8'h45, a);
        end
        check_val("step_enable_cycles", 64'(en_count - base), 64'(n));
        check_idle_state("step");
        $display("step n=%0d by_end=%0d count=%0d", n, by_end, o_cycle_count);
    endtask

    task automatic bad_cmd(input logic [7:0] b);
        int a;
        send(b, a);
        push_ev(EV_ERROR, 0, a);
        idle(1);
        check_idle_state("err");
        $display("bad command %02h", b);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_we"}, 64'(o_load_program_write_enable), 64'd0);
        check_val({tag, "_byte"}, 64'(o_load_program_byte), 64'd0);
        check_val({tag, "_pc_reset"}, 64'(o_pc_reset), 64'd0);
        check_val({tag, "_enable"}, 64'(o_pipeline_enable), 64'd0);
        check_val({tag, "_state"}, 64'(o_state), 64'd0);
        check_val({tag, "_count"}, 64'(o_cycle_count), 64'd0);
        check_val({tag, "_done"}, 64'(o_done), 64'd0);
        check_val({tag, "_error"}, 64'(o_error), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int a;
        int op;
        logic [7:0] b;
        #1;
        check_all_zero("in_reset");
        idle(2);
        i_reset = 1'b0;
        check_all_zero("post_reset");
        check_val("post_reset_ready", 64'(o_cmd_ready), 64'd1);
        $display("reset released at cycle %0d", cyc);

        load_prog(8, 0, 0);
        load_prog(0, 1, 0);
        run_prog(10, 1'b0);
        step_prog(3, 1'b0, 1'b1);
        step_prog(3, 1'b1, 1'b0);
        bad_cmd(8'h99);
        run_prog(0, 1'b1);

        // Async reset after 3 of 8 load bytes.
        send(8'h4C, a); send(8'h08, a); send(8'h00, a);
        for (int i = 0; i < 3; i++) begin
            send(8'(8'hA0 + i), a);
            push_ev(EV_STROBE, 32'hA0 + i, a);
        end
        @(negedge i_clock); #1;
        i_reset = 1'b1;
        #1;
        check_all_zero("reset_mid_load");
        @(posedge i_clock); #1;
        i_reset = 1'b0;
        model_count = 0;
        $display("reset mid-load applied");
        load_prog(8, 0, 0);

        // Async reset while running.
        send(8'h43, a);
        idle(3);
        @(negedge i_clock); #1;
        check_val("run_enable_before_reset", 64'(o_pipeline_enable), 64'd1);
        i_reset = 1'b1;
        #1;
        check_all_zero("reset_mid_run");
        @(posedge i_clock); #1;
        i_reset = 1'b0;
        model_count = 0;
        check_idle_state("after_run_reset");
        $display("reset mid-run applied");

        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(3, 0);
            case (op)
                0: load_prog($urandom_range(12, 0), 1, 2);
                1: run_prog($urandom_range(20, 0), 1'b0);
                2: step_prog($urandom_range(4, 0), 1'($urandom_range(1, 0)), 1'b0);
                default: begin
                    do b = 8'($urandom); while (b == 8'h4C || b == 8'h43 || b == 8'h53);
                    bad_cmd(b);
                end
            endcase
        end

        load_prog(261, 1, 0);
        idle(2);
        check_val("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
